// File: rtl/axis_frame_packetizer.sv
// Regroups a merged AXI4-Stream into bounded packets: tlast closes on upstream tlast, a beat
// limit, or an idle timeout. A one-beat hold register delays each beat until its tlast is known.
module axis_frame_packetizer #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned MAX_PKT_LEN = 256,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  timeout_count
);

  localparam int unsigned IdleW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IdleW-1:0] IdleLast = IdleW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [15:0] MaxLen = 16'(MAX_PKT_LEN);

  logic                  h_valid_q, h_valid_d;
  logic [DATA_WIDTH-1:0] h_data_q, h_data_d;
  logic                  h_final_q, h_final_d;
  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic                  o_last_q, o_last_d;
  logic [15:0]           beat_cnt_q, beat_cnt_d;
  logic [IdleW-1:0]      idle_cnt_q, idle_cnt_d;
  logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
  logic [CNT_WIDTH-1:0]  timeout_count_q, timeout_count_d;

  logic        o_free, h_move, s_hs, idle_inc, tmo_fire;
  logic [15:0] beat_base, beat_next;

  always_comb begin
    o_free        = !o_valid_q || m_axis_tready;
    // A non-final beat may only leave H once its successor proves it is not the packet end.
    h_move        = h_valid_q && o_free && (h_final_q || s_axis_tvalid);
    s_axis_tready = !h_valid_q || h_move;
    s_hs          = s_axis_tvalid && s_axis_tready;
    idle_inc      = (TIMEOUT != 0) && h_valid_q && !h_final_q && !s_axis_tvalid;
    tmo_fire      = idle_inc && (idle_cnt_q == IdleLast);
    beat_base     = (h_move && h_final_q) ? 16'd0 : beat_cnt_q;
    beat_next     = beat_base + 16'd1;

    h_valid_d       = h_valid_q;
    h_data_d        = h_data_q;
    h_final_d       = h_final_q;
    beat_cnt_d      = beat_cnt_q;
    idle_cnt_d      = (idle_inc && !tmo_fire) ? idle_cnt_q + IdleW'(1) : '0;
    o_valid_d       = o_valid_q;
    o_data_d        = o_data_q;
    o_last_d        = o_last_q;
    pkt_count_d     = pkt_count_q;
    timeout_count_d = timeout_count_q;

    if (h_move) begin
      h_valid_d = 1'b0;
      h_final_d = 1'b0;
      if (h_final_q) beat_cnt_d = '0;
    end
    if (s_hs) begin
      h_valid_d  = 1'b1;
      h_data_d   = s_axis_tdata;
      h_final_d  = s_axis_tlast || (beat_next == MaxLen);
      beat_cnt_d = beat_next;
    end
    // Latched in H so a blocked output still closes the packet once it frees.
    if (tmo_fire) begin
      h_final_d       = 1'b1;
      timeout_count_d = timeout_count_q + CNT_WIDTH'(1);
    end

    if (o_free) begin
      o_valid_d = h_move;
      if (h_move) begin
        o_data_d = h_data_q;
        o_last_d = h_final_q;
      end
    end
    if (o_valid_q && m_axis_tready && o_last_q) pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_valid_q       <= 1'b0;
      h_data_q        <= '0;
      h_final_q       <= 1'b0;
      o_valid_q       <= 1'b0;
      o_data_q        <= '0;
      o_last_q        <= 1'b0;
      beat_cnt_q      <= '0;
      idle_cnt_q      <= '0;
      pkt_count_q     <= '0;
      timeout_count_q <= '0;
    end else begin
      h_valid_q       <= h_valid_d;
      h_data_q        <= h_data_d;
      h_final_q       <= h_final_d;
      o_valid_q       <= o_valid_d;
      o_data_q        <= o_data_d;
      o_last_q        <= o_last_d;
      beat_cnt_q      <= beat_cnt_d;
      idle_cnt_q      <= idle_cnt_d;
      pkt_count_q     <= pkt_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign m_axis_tvalid = o_valid_q;
  assign m_axis_tdata  = o_data_q;
  assign m_axis_tlast  = o_last_q;
  assign pkt_count     = pkt_count_q;
  assign timeout_count = timeout_count_q;

endmodule
